// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, frame layout and the protocol
// prefix codes that the keycode decode stage also uses.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    // Bit positions inside the 10-bit shift register once a frame is complete.
    localparam int PS2_STOP_IDX = 9;
    localparam int PS2_PAR_IDX  = 8;

    // Odd parity over data plus parity bit: the XOR of all nine must be 1.
    function automatic logic ps2_parity_ok(input logic [8:0] data_par);
        return ^data_par;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on both pins, a FILTER_LEN-sample
// deglitcher on the clock line, and a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic ps2d_s,
    output logic fall_edge
);

    logic                  ps2c_meta_q, ps2c_s_q;
    logic                  ps2d_meta_q, ps2d_s_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  f_ps2c_q, f_ps2c_d;
    logic                  fall_edge_q, fall_edge_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        filt_d   = {ps2c_s_q, filt_q[FILTER_LEN-1:1]};
        f_ps2c_d = f_ps2c_q;
        if (&filt_q) begin
            f_ps2c_d = 1'b1;
        end else if (~|filt_q) begin
            f_ps2c_d = 1'b0;
        end
        fall_edge_d = f_ps2c_q & ~f_ps2c_d;
    end

    // Bus idles high, so everything resets to 1 to avoid a false edge out of reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_meta_q <= 1'b1;
            ps2c_s_q    <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_s_q    <= 1'b1;
            filt_q      <= '1;
            f_ps2c_q    <= 1'b1;
            fall_edge_q <= 1'b0;
        end else begin
            ps2c_meta_q <= ps2c;
            ps2c_s_q    <= ps2c_meta_q;
            ps2d_meta_q <= ps2d;
            ps2d_s_q    <= ps2d_meta_q;
            filt_q      <= filt_d;
            f_ps2c_q    <= f_ps2c_d;
            fall_edge_q <= fall_edge_d;
        end
    end

    assign ps2d_s    = ps2d_s_q;
    assign fall_edge = fall_edge_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Define PS2_PARITY_CHECK_EN to reject frames with bad parity; otherwise only stop is checked.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    // Abort when the counter would step onto TIMEOUT_CYC-1, so the error pulse
    // lands exactly TIMEOUT_CYC cycles after the last edge.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

    logic ps2d_s;
    logic fall_edge;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2c     (ps2c),
        .ps2d     (ps2d),
        .ps2d_s   (ps2d_s),
        .fall_edge(fall_edge)
    );

    ps2_state_e       state_q, state_d;
    logic [3:0]       n_q, n_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [9:0]       b_q, b_d;
    logic [7:0]       dout_q, dout_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             frame_ok;

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = b_q[PS2_STOP_IDX] & ps2_parity_ok(b_q[PS2_PAR_IDX:0]);
`else
    assign frame_ok = b_q[PS2_STOP_IDX];
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        tmo_d   = tmo_q;
        b_d     = b_q;
        dout_d  = dout_q;
        tick_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_edge && rx_en && !ps2d_s) begin
                    state_d = RECV;
                    n_d     = 4'd9;
                    tmo_d   = '0;
                end
            end
            RECV: begin
                if (fall_edge) begin
                    b_d   = {ps2d_s, b_q[9:1]};
                    tmo_d = '0;
                    if (n_q == 4'd0) begin
                        state_d = CHECK;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_ok) begin
                    dout_d = b_q[7:0];
                    tick_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            tmo_q   <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            tmo_q   <= tmo_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = tick_q;
    assign frame_err    = err_q;

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
PS/2 device-to-host serial receiver feeding the keycode decode stage. It synchronises and deglitches the raw PS/2 clock and data lines, and deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop). Each valid byte is presented on dout with a one-cycle rx_done_tick. Break prefix 0xF0 and extended prefix 0xE0 pass through as ordinary bytes; release handling belongs downstream.

Parameters:
FILTER_LEN, 8, number of consecutive identical synced ps2c samples required to change the filtered clock level
TIMEOUT_CYC, 50000, clk cycles without a filtered falling edge mid-frame before the frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ps2c  input  1  raw PS/2 clock pin, asynchronous
ps2d  input  1  raw PS/2 data pin, asynchronous
rx_en  input  1  enables start-of-frame detection
dout  output  8  last valid received byte
rx_done_tick  output  1  one-cycle pulse; dout valid and updated in the same cycle
frame_err  output  1  one-cycle pulse on bad stop, bad parity (see feature) or timeout

Behaviour:
- Reset: clk is clk; reset is reset, synchronous, active-high. On reset: dout=0x00, rx_done_tick=0, frame_err=0, state=IDLE, bit counter=0, timeout counter=0. Synchroniser and filter registers are all 1 (idle-high bus).
- Sync: ps2c and ps2d each pass through 2 flops before use (ps2c_s, ps2d_s).
- Filter: FILTER_LEN-bit shift of ps2c_s. f_ps2c goes 1 when all bits are 1 and 0 when all bits are 0; otherwise it holds. fall_edge pulses one cycle on an f_ps2c 1->0 transition.
- State machine: IDLE, RECV, CHECK.
- IDLE: fall_edge && rx_en && ps2d_s==0 -> RECV, n=9, timeout counter cleared. A fall_edge with ps2d_s==1 or rx_en==0 is ignored.
- RECV: on each fall_edge, b_reg[9:0] <= {ps2d_s, b_reg[9:1]}. If n==0 -> CHECK; else n-1, and the timeout counter clears. With no fall_edge, the timeout counter increments. When it reaches TIMEOUT_CYC-1 -> IDLE, frame_err pulses, and b_reg is discarded.
- CHECK (exactly 1 cycle, then IDLE): b_reg[9]=stop, b_reg[8]=parity, b_reg[7:0]=data.
  - Valid frame: dout<=data and rx_done_tick=1 in the same cycle.
  - Invalid frame: frame_err=1; dout and rx_done_tick are unchanged (tick stays 0).
- Latency: rx_done_tick rises exactly 2 clk cycles after the fall_edge pulse that samples the stop bit.
- Deasserting rx_en mid-frame does not abort the frame; rx_en gates start only.
- rx_done_tick and frame_err never assert in the same cycle.
- dout holds its value between frames.
- Reset mid-frame returns to IDLE immediately; the partial frame is lost and no pulse is generated.
- A fall_edge arriving in CHECK is ignored; the host-side 60+ us bit period makes this unreachable in legal traffic.

Optional Feature:
PS2_PARITY_CHECK_EN:
- Defined: CHECK also requires ^b_reg[8:0]==1 (odd parity). A mismatch gives frame_err and no tick.
- Undefined: parity bit is sampled but ignored; only stop==1 is checked.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, RECV, CHECK)
  - PS2_FRAME_BITS=11
  - PS2_BREAK_CODE=8'hF0
  - PS2_EXT_CODE=8'hE0
  - bit-index constants for stop and parity
  - shared with the decode stage
- One sub-module, ps2_clk_filter: 2-flop synchronisers for both lines, FILTER_LEN deglitch, fall_edge output. The FSM stays in ps2_rx_frame.

Test Plan:
- Send frame 0x1C (parity 0, stop 1), bit period 4000 clk -> one rx_done_tick, dout=0x1C, frame_err never asserts.
- Send 0xF0 (parity 1) then 0x1C -> two ticks, dout sequence 0xF0, 0x1C, exactly 2 cycles after each stop-bit edge.
- 0x1C with parity 1:
  - with PS2_PARITY_CHECK_EN -> frame_err pulse, no tick, dout keeps previous value.
  - without -> tick, dout=0x1C.
- Stop bit 0 on 0x75 -> frame_err pulse, no tick. Next valid 0x75 frame -> tick, dout=0x75.
- 3-cycle low glitch on ps2c in IDLE and mid-frame (FILTER_LEN=8) -> no fall_edge, no extra bit; the frame 0x6B still decodes correctly.
- Start + 4 data bits then stall -> frame_err exactly TIMEOUT_CYC cycles after the last edge, state IDLE. Next frame 0x72 decodes. Repeat the stall case with reset asserted at bit 5 -> no pulses, and the next frame decodes.
